alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Producer side of the EX-stage ALU interface.
- Decodes the ID-stage RV32I instruction fields into the 5-bit ALU control code and selects operand A and operand B.
- Registers the results into the ID/EX pipeline register, with a valid/ready handshake plus stall and flush control.
- Outputs drive the ALU control and operand inputs directly.

Parameters:
- WIDTH, 32, datapath width of the PC, register operands and immediate.
- CNT_WIDTH, 32, width of the accepted-instruction counter.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid_ID  input  1  ID stage presents an instruction.
- o_ready_ID  output  1  stage accepts the ID instruction this cycle.
- i_instr_ID  input  32  raw instruction (opcode [6:0], funct3 [14:12], funct7 [31:25]).
- i_pc_ID  input  WIDTH  instruction PC.
- i_rd1_ID  input  WIDTH  rs1 value.
- i_rd2_ID  input  WIDTH  rs2 value.
- i_imm_ID  input  WIDTH  immediate, already sign-extended/shifted by decode.
- i_stall_EX  input  1  EX cannot advance.
- i_flush_EX  input  1  kill EX-stage contents and the incoming instruction.
- o_alu_ctrl_EX  output  5  ALU operation code.
- o_src_a_EX  output  WIDTH  ALU operand A.
- o_src_b_EX  output  WIDTH  ALU operand B.
- o_valid_EX  output  1  EX register holds a live instruction.
- o_branch_EX  output  1  live instruction is a conditional branch.
- o_illegal_EX  output  1  live instruction failed decode (optional feature only).
- o_issue_count  output  CNT_WIDTH  number of instructions accepted.

Behaviour:
- ALU codes: AND=0, OR=1, XOR=2, ADD=3, SUB=4, SLL=5, SRL=6, SLT=7, SLTU=8, SRA=9, BEQ=10, BNE=11, BLT=12, BLTU=13, BGE=14, BGEU=15, LUI=16.
- OP (0110011), by funct3:
  - 000: ADD when funct7=0000000, SUB when funct7=0100000.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 101: SRL when funct7=0000000, SRA when funct7=0100000.
  - Any other funct7 is illegal.
- OP-IMM (0010011): same mapping, except:
  - funct3=000 is always ADD.
  - 001 requires funct7=0000000.
  - 101 uses funct7 to select SRL/SRA; any other funct7 is illegal.
- BRANCH (1100011): funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 are illegal.
- ADD opcodes: LOAD 0000011, STORE 0100011, AUIPC 0010111, JAL 1101111, JALR 1100111.
- LUI 0110111 maps to LUI.
- Every other opcode is illegal.
- Operand A: i_pc_ID for AUIPC and JAL, otherwise i_rd1_ID.
- Operand B: i_rd2_ID for OP and BRANCH, otherwise i_imm_ID.
- Illegal decode without the feature: code ADD, operands per the default rules.
- o_ready_ID = ~i_stall_EX | ~o_valid_EX. A bubble in EX never blocks ID.
- Accept condition = i_valid_ID & o_ready_ID & ~i_flush_EX.
- Register update priority per clock:
  1. i_flush_EX: o_valid_EX, o_branch_EX and o_illegal_EX cleared to 0. Data fields hold. Incoming instruction dropped and not counted.
  2. Else, if i_stall_EX and o_valid_EX: all outputs hold.
  3. Else: load the decoded ctrl/operands. o_valid_EX <= i_valid_ID. o_branch_EX <= i_valid_ID & is_branch. When i_valid_ID=0, data fields hold.
- o_issue_count increments by 1 on each accept and wraps modulo 2^CNT_WIDTH. It is unaffected by a later flush.
- Latency: exactly one cycle from accept to o_valid_EX.
- Reset (async assert, any time, including mid-stall): o_alu_ctrl_EX=0, o_src_a_EX=0, o_src_b_EX=0, o_valid_EX=0, o_branch_EX=0, o_illegal_EX=0, o_issue_count=0.
- During reset o_ready_ID=1.
- Deassertion is expected to be synchronised upstream; the first edge after it behaves as a normal cycle.

Optional Feature:
- Macro: ALU_ISSUE_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal decode that is accepted loads o_illegal_EX=1, o_valid_EX=0, code AND.
  - It still counts in o_issue_count.
  - o_illegal_EX clears on the next load or on flush.
- Undefined: o_illegal_EX is tied to 0 and illegal decodes issue as ADD with o_valid_EX=1.

Test Plan:
- Reset then ADD x3,x1,x2 (0x002081B3), rd1=5, rd2=7, valid=1 → next cycle: ctrl=3, src_a=5, src_b=7, valid_EX=1, issue_count=1.
- SUB 0x40208233, then SRAI (0x4030D193) with imm=3 → ctrl=4, then ctrl=9 with src_b=3.
- BLTU 0x0020E463 with pc=0x100 → ctrl=13, src_a=rd1, src_b=rd2, branch_EX=1.
- AUIPC with pc=0x1000, imm=0x2000 → ctrl=3, src_a=0x1000, src_b=0x2000.
- Live instruction in EX, stall=1 for 3 cycles with a new valid ID instruction → ready_ID=0 and outputs frozen for 3 cycles. Stall drops → new instruction loads the next cycle; count +1.
- flush=1 together with a valid ID instruction → valid_EX=0, branch_EX=0, count unchanged.
- Opcode 0x7F with the macro defined → illegal_EX=1, valid_EX=0. Macro undefined → ctrl=3, valid_EX=1.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes RV32I fields into an ALU control code, selects
// operands, and registers them behind a valid/ready handshake with stall and
// flush control. Optional illegal-instruction trap: ALU_ISSUE_ILLEGAL_TRAP_EN.
module alu_issue_stage #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid_ID,
    output logic                 o_ready_ID,
    input  logic [31:0]          i_instr_ID,
    input  logic [WIDTH-1:0]     i_pc_ID,
    input  logic [WIDTH-1:0]     i_rd1_ID,
    input  logic [WIDTH-1:0]     i_rd2_ID,
    input  logic [WIDTH-1:0]     i_imm_ID,
    input  logic                 i_stall_EX,
    input  logic                 i_flush_EX,
    output logic [4:0]           o_alu_ctrl_EX,
    output logic [WIDTH-1:0]     o_src_a_EX,
    output logic [WIDTH-1:0]     o_src_b_EX,
    output logic                 o_valid_EX,
    output logic                 o_branch_EX,
    output logic                 o_illegal_EX,
    output logic [CNT_WIDTH-1:0] o_issue_count
);
    localparam logic [4:0] C_AND = 5'd0,  C_OR   = 5'd1,  C_XOR  = 5'd2,  C_ADD = 5'd3,
                           C_SUB = 5'd4,  C_SLL  = 5'd5,  C_SRL  = 5'd6,  C_SLT = 5'd7,
                           C_SLTU = 5'd8, C_SRA  = 5'd9,  C_BEQ  = 5'd10, C_BNE = 5'd11,
                           C_BLT = 5'd12, C_BLTU = 5'd13, C_BGE  = 5'd14, C_BGEU = 5'd15,
                           C_LUI = 5'd16;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_BR = 7'b1100011,
                           OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_AUIPC = 7'b0010111,
                           OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;

    typedef struct packed {
        logic [4:0] ctrl;
        logic       illegal;
        logic       is_branch;
        logic       sel_pc;   // operand A from PC
        logic       sel_rs2;  // operand B from rs2
    } dec_t;

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic       f7_zero, f7_alt;
    dec_t       dec;
    logic       accept;

    assign opcode  = i_instr_ID[6:0];
    assign f3      = i_instr_ID[14:12];
    assign f7      = i_instr_ID[31:25];
    assign f7_zero = (f7 == 7'b0000000);
    assign f7_alt  = (f7 == 7'b0100000);

    // Instruction decode into ALU code, operand selects and legality
    always_comb begin
        dec = '{ctrl: C_ADD, illegal: 1'b0, is_branch: 1'b0, sel_pc: 1'b0, sel_rs2: 1'b0};
        unique case (opcode)
            OP_R, OP_I: begin
                dec.sel_rs2 = (opcode == OP_R);
                unique case (f3)
                    3'b000: begin
                        if (opcode == OP_I)  dec.ctrl = C_ADD;
                        else if (f7_zero)    dec.ctrl = C_ADD;
                        else if (f7_alt)     dec.ctrl = C_SUB;
                        else                 dec.illegal = 1'b1;
                    end
                    3'b101: begin
                        if (f7_zero)         dec.ctrl = C_SRL;
                        else if (f7_alt)     dec.ctrl = C_SRA;
                        else                 dec.illegal = 1'b1;
                    end
                    default: begin
                        case (f3)
                            3'b001:  dec.ctrl = C_SLL;
                            3'b010:  dec.ctrl = C_SLT;
                            3'b011:  dec.ctrl = C_SLTU;
                            3'b100:  dec.ctrl = C_XOR;
                            3'b110:  dec.ctrl = C_OR;
                            default: dec.ctrl = C_AND;
                        endcase
                        // OP-IMM only constrains funct7 on the shift-left form
                        if (!f7_zero && (opcode == OP_R || f3 == 3'b001)) dec.illegal = 1'b1;
                    end
                endcase
            end
            OP_BR: begin
                dec.sel_rs2   = 1'b1;
                dec.is_branch = 1'b1;
                case (f3)
                    3'b000:  dec.ctrl = C_BEQ;
                    3'b001:  dec.ctrl = C_BNE;
                    3'b100:  dec.ctrl = C_BLT;
                    3'b101:  dec.ctrl = C_BGE;
                    3'b110:  dec.ctrl = C_BLTU;
                    3'b111:  dec.ctrl = C_BGEU;
                    default: begin dec.illegal = 1'b1; dec.is_branch = 1'b0; end
                endcase
            end
            OP_AUIPC, OP_JAL:        dec.sel_pc = 1'b1;
            OP_LD, OP_ST, OP_JALR:   dec.ctrl   = C_ADD;
            OP_LUI:                  dec.ctrl   = C_LUI;
            default:                 dec.illegal = 1'b1;
        endcase
        // Illegal decodes fall back to ADD unless the trap overrides below
        if (dec.illegal) dec.ctrl = C_ADD;
    end

    assign o_ready_ID = ~i_stall_EX | ~o_valid_EX;
    assign accept     = i_valid_ID & o_ready_ID & ~i_flush_EX;

    // ID/EX register: flush beats stall beats load
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_alu_ctrl_EX <= '0;
            o_src_a_EX    <= '0;
            o_src_b_EX    <= '0;
            o_valid_EX    <= 1'b0;
            o_branch_EX   <= 1'b0;
            o_illegal_EX  <= 1'b0;
        end else if (i_flush_EX) begin
            o_valid_EX   <= 1'b0;
            o_branch_EX  <= 1'b0;
            o_illegal_EX <= 1'b0;
        end else if (!(i_stall_EX && o_valid_EX)) begin
            if (i_valid_ID) begin
                o_src_a_EX <= dec.sel_pc  ? i_pc_ID  : i_rd1_ID;
                o_src_b_EX <= dec.sel_rs2 ? i_rd2_ID : i_imm_ID;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                o_alu_ctrl_EX <= dec.illegal ? C_AND : dec.ctrl;
`else
                o_alu_ctrl_EX <= dec.ctrl;
`endif
            end
            o_branch_EX <= i_valid_ID & dec.is_branch;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            o_valid_EX   <= i_valid_ID & ~dec.illegal;
            o_illegal_EX <= i_valid_ID & dec.illegal;
`else
            o_valid_EX   <= i_valid_ID;
            o_illegal_EX <= 1'b0;
`endif
        end
    end

    // Accepted-instruction counter; later flushes do not rewind it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    o_issue_count <= '0;
        else if (accept) o_issue_count <= o_issue_count + 1'b1;
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a decode vector table plus hand-written
// stall, flush, bubble and async-reset sequences.
module tb_alu_issue_stage;
    localparam int W = 32;

    logic          clk, rst_n;
    logic          valid_id, ready_id, stall, flush;
    logic [31:0]   instr;
    logic [W-1:0]  pc, rd1, rd2, imm;
    logic [4:0]    ctrl;
    logic [W-1:0]  src_a, src_b;
    logic          valid_ex, branch_ex, illegal_ex;
    logic [31:0]   cnt;

    int checks = 0, errors = 0;
    logic [31:0] exp_cnt = 0;

    alu_issue_stage #(.WIDTH(W), .CNT_WIDTH(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid_ID(valid_id), .o_ready_ID(ready_id),
        .i_instr_ID(instr), .i_pc_ID(pc), .i_rd1_ID(rd1), .i_rd2_ID(rd2), .i_imm_ID(imm),
        .i_stall_EX(stall), .i_flush_EX(flush), .o_alu_ctrl_EX(ctrl), .o_src_a_EX(src_a),
        .o_src_b_EX(src_b), .o_valid_EX(valid_ex), .o_branch_EX(branch_ex),
        .o_illegal_EX(illegal_ex), .o_issue_count(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr, pc, rd1, rd2, imm;
        logic [4:0]  ctrl;
        logic [31:0] a, b;
        logic        br, ill;
    } vec_t;

    vec_t vt[15];

    initial begin
        logic [4:0] e_ctrl;
        logic       e_vld, e_ill;
        logic [4:0] hold_ctrl;
        logic [31:0] hold_a, hold_b;

        vt[0]  = '{"add",    32'h002081B3, 32'h0,    32'd5,  32'd7,  32'h0,    5'd3,  32'd5,    32'd7,    1'b0, 1'b0};
        vt[1]  = '{"sub",    32'h40208233, 32'h0,    32'd10, 32'd3,  32'h0,    5'd4,  32'd10,   32'd3,    1'b0, 1'b0};
        vt[2]  = '{"srai",   32'h4030D193, 32'h0,    32'hF0, 32'd99, 32'd3,    5'd9,  32'hF0,   32'd3,    1'b0, 1'b0};
        vt[3]  = '{"bltu",   32'h0020E463, 32'h100,  32'd1,  32'd2,  32'd8,    5'd13, 32'd1,    32'd2,    1'b1, 1'b0};
        vt[4]  = '{"auipc",  32'h00002097, 32'h1000, 32'd4,  32'd6,  32'h2000, 5'd3,  32'h1000, 32'h2000, 1'b0, 1'b0};
        vt[5]  = '{"lui",    32'h000010B7, 32'h40,   32'd9,  32'd6,  32'h1000, 5'd16, 32'd9,    32'h1000, 1'b0, 1'b0};
        vt[6]  = '{"xori",   32'h0040C093, 32'h0,    32'd3,  32'd6,  32'd4,    5'd2,  32'd3,    32'd4,    1'b0, 1'b0};
        vt[7]  = '{"beq",    32'h00208463, 32'h80,   32'd11, 32'd12, 32'd8,    5'd10, 32'd11,   32'd12,   1'b1, 1'b0};
        vt[8]  = '{"bge",    32'h0020D463, 32'h80,   32'd13, 32'd14, 32'd8,    5'd14, 32'd13,   32'd14,   1'b1, 1'b0};
        vt[9]  = '{"sltu",   32'h0020B1B3, 32'h0,    32'd21, 32'd22, 32'd1,    5'd8,  32'd21,   32'd22,   1'b0, 1'b0};
        vt[10] = '{"load",   32'h0000A083, 32'h0,    32'h300,32'd5,  32'h10,   5'd3,  32'h300,  32'h10,   1'b0, 1'b0};
        vt[11] = '{"jal",    32'h0000006F, 32'h200,  32'd1,  32'd2,  32'h20,   5'd3,  32'h200,  32'h20,   1'b0, 1'b0};
        vt[12] = '{"ill_op", 32'h0000007F, 32'h0,    32'd31, 32'd32, 32'd33,   5'd3,  32'd31,   32'd33,   1'b0, 1'b1};
        vt[13] = '{"ill_sl", 32'h40209093, 32'h0,    32'd41, 32'd42, 32'd43,   5'd3,  32'd41,   32'd43,   1'b0, 1'b1};
        vt[14] = '{"ill_br", 32'h0020A463, 32'h0,    32'd51, 32'd52, 32'd53,   5'd3,  32'd51,   32'd52,   1'b0, 1'b1};

        rst_n = 1'b0; valid_id = 0; stall = 0; flush = 0;
        instr = 0; pc = 0; rd1 = 0; rd2 = 0; imm = 0;
        #12;
        chk("rst_ready", ready_id, 1);
        chk("rst_ctrl",  ctrl, 0);
        chk("rst_a",     src_a, 0);
        chk("rst_b",     src_b, 0);
        chk("rst_valid", valid_ex, 0);
        chk("rst_br",    branch_ex, 0);
        chk("rst_ill",   illegal_ex, 0);
        chk("rst_cnt",   cnt, 0);
        @(negedge clk); rst_n = 1'b1;

        // Decode table, one instruction per cycle
        for (int i = 0; i < 15; i++) begin
            instr = vt[i].instr; pc = vt[i].pc; rd1 = vt[i].rd1;
            rd2 = vt[i].rd2; imm = vt[i].imm; valid_id = 1;
            tick();
            exp_cnt++;
            e_ctrl = vt[i].ctrl; e_vld = 1'b1; e_ill = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            if (vt[i].ill) begin e_ctrl = 5'd0; e_vld = 1'b0; e_ill = 1'b1; end
`endif
            chk({vt[i].name, "_ctrl"}, ctrl, e_ctrl);
            chk({vt[i].name, "_a"},    src_a, vt[i].a);
            chk({vt[i].name, "_b"},    src_b, vt[i].b);
            chk({vt[i].name, "_vld"},  valid_ex, e_vld);
            chk({vt[i].name, "_br"},   branch_ex, vt[i].br);
            chk({vt[i].name, "_ill"},  illegal_ex, e_ill);
            chk({vt[i].name, "_cnt"},  cnt, exp_cnt);
        end

        // Stall: live ADD held for 3 cycles while a SUB waits upstream
        instr = 32'h002081B3; rd1 = 32'd100; rd2 = 32'd200; imm = 0; pc = 0;
        tick(); exp_cnt++;
        chk("stall_pre_vld", valid_ex, 1);
        chk("stall_pre_ill", illegal_ex, 0);
        instr = 32'h40208233; rd1 = 32'd77; rd2 = 32'd7; stall = 1;
        #1;
        chk("stall_ready", ready_id, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_ready_c", ready_id, 0);
            chk("stall_ctrl",    ctrl, 5'd3);
            chk("stall_a",       src_a, 32'd100);
            chk("stall_b",       src_b, 32'd200);
            chk("stall_vld",     valid_ex, 1);
            chk("stall_cnt",     cnt, exp_cnt);
        end
        stall = 0;
        tick(); exp_cnt++;
        chk("unstall_ctrl", ctrl, 5'd4);
        chk("unstall_a",    src_a, 32'd77);
        chk("unstall_b",    src_b, 32'd7);
        chk("unstall_cnt",  cnt, exp_cnt);

        // Flush: live BEQ killed, incoming instruction dropped and not counted
        instr = 32'h00208463; rd1 = 32'd1; rd2 = 32'd2;
        tick(); exp_cnt++;
        chk("flush_pre_br", branch_ex, 1);
        instr = 32'h0020D463; rd1 = 32'd5; rd2 = 32'd6; flush = 1;
        tick();
        chk("flush_vld",  valid_ex, 0);
        chk("flush_br",   branch_ex, 0);
        chk("flush_cnt",  cnt, exp_cnt);
        chk("flush_ctrl", ctrl, 5'd10);
        chk("flush_a",    src_a, 32'd1);
        flush = 0;

        // Bubble: valid drops, data fields hold, bubble does not block with stall
        instr = 32'h002081B3; rd1 = 32'd3; rd2 = 32'd4;
        tick(); exp_cnt++;
        valid_id = 0; rd1 = 32'hDEAD;
        tick();
        chk("bub_vld",  valid_ex, 0);
        chk("bub_a",    src_a, 32'd3);
        chk("bub_cnt",  cnt, exp_cnt);
        stall = 1; #1;
        chk("bub_ready", ready_id, 1);

        // Async reset mid-stall with a live instruction
        stall = 0; valid_id = 1; rd1 = 32'd9;
        tick();
        stall = 1;
        tick();
        chk("mrst_pre_vld", valid_ex, 1);
        #2 rst_n = 1'b0; #1;
        chk("mrst_vld",   valid_ex, 0);
        chk("mrst_a",     src_a, 0);
        chk("mrst_ctrl",  ctrl, 0);
        chk("mrst_cnt",   cnt, 0);
        chk("mrst_ready", ready_id, 1);
        @(negedge clk); rst_n = 1'b1; valid_id = 0; stall = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
